// File: rtl/stdin_if.sv
// stdin_if: handshake bundle between the UART byte stream, the stdin parser and the machine.
//   uart_val_i / uart_data_i[7:0] / uart_rdy_o    : ASCII bytes into the parser
//   stdin_val_o / stdin_data_o[15:0] / stdin_rdy_i : parsed decimal word out of the parser
//   echo_val_o / echo_data_o[7:0] / echo_rdy_i     : echo of accepted bytes (STDIN_ECHO_EN only)
// Signal suffixes are from the parser's point of view; modport slave is the parser,
// modport master is its environment. Optional feature macro: STDIN_ECHO_EN.
interface stdin_if;
    logic        uart_val_i;
    logic [7:0]  uart_data_i;
    logic        uart_rdy_o;
    logic        stdin_val_o;
    logic [15:0] stdin_data_o;
    logic        stdin_rdy_i;
`ifdef STDIN_ECHO_EN
    logic        echo_val_o;
    logic [7:0]  echo_data_o;
    logic        echo_rdy_i;
    modport slave (
        input  uart_val_i, uart_data_i, stdin_rdy_i, echo_rdy_i,
        output uart_rdy_o, stdin_val_o, stdin_data_o, echo_val_o, echo_data_o
    );
    modport master (
        output uart_val_i, uart_data_i, stdin_rdy_i, echo_rdy_i,
        input  uart_rdy_o, stdin_val_o, stdin_data_o, echo_val_o, echo_data_o
    );
`else
    modport slave (
        input  uart_val_i, uart_data_i, stdin_rdy_i,
        output uart_rdy_o, stdin_val_o, stdin_data_o
    );
    modport master (
        output uart_val_i, uart_data_i, stdin_rdy_i,
        input  uart_rdy_o, stdin_val_o, stdin_data_o
    );
`endif
endinterface

// File: rtl/stdin.sv
// stdin: parses an ASCII byte stream into decimal words of up to four digits.
//   clk_i          : sole clock, rising edge
//   rst_i          : synchronous active-high reset
//   bus            : stdin_if.slave (UART byte in, parsed word out, optional echo)
//   lcd_bcd_o[0:3] : BCD digits of the token being typed, [0] least significant
//   err_o          : one-cycle pulse when a token is rejected
// Optional feature macro: STDIN_ECHO_EN (echo every accepted byte before continuing).
module stdin (
    input  logic       clk_i,
    input  logic       rst_i,
    stdin_if.slave     bus,
    output logic [3:0] lcd_bcd_o [0:3],
    output logic       err_o
);
    typedef enum logic [2:0] {
        IDLE, ACCUM, DISCARD, EMIT
`ifdef STDIN_ECHO_EN
        , ECHO
`endif
    } state_e;
    state_e      state_q, state_d, tok_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  bcd_q [0:3];
    logic [3:0]  bcd_d [0:3];
    logic [15:0] data_q, data_d;
    logic        err_q, err_d;
    logic        acc, is_dig, is_del, is_bs;
    logic [7:0]  b;
`ifdef STDIN_ECHO_EN
    state_e      ret_q, ret_d;
    logic [7:0]  echo_q, echo_d;
    assign bus.echo_val_o  = state_q == ECHO;
    assign bus.echo_data_o = echo_q;
`endif
    assign b               = bus.uart_data_i;
    assign is_dig          = b >= 8'h30 && b <= 8'h39;
    assign is_del          = b == 8'h20 || b == 8'h0a || b == 8'h0d;
    assign is_bs           = b == 8'h08;
    assign bus.uart_rdy_o  = state_q == IDLE || state_q == ACCUM || state_q == DISCARD;
    assign acc             = bus.uart_val_i && bus.uart_rdy_o;
    assign bus.stdin_val_o = state_q == EMIT;
    assign bus.stdin_data_o = data_q;
    assign lcd_bcd_o       = bcd_q;
    assign err_o           = err_q;
    // tok_d is the state the accepted byte leads to; with echo it is parked in ret_q
    // while the echo handshake completes, but digits/count/error update immediately.
    always_comb begin
        tok_d  = state_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
        data_d = data_q;
        err_d  = 1'b0;
`ifdef STDIN_ECHO_EN
        ret_d  = ret_q;
        echo_d = echo_q;
`endif
        if (acc && is_dig && state_q == IDLE) begin
            bcd_d = '{b[3:0], 4'd0, 4'd0, 4'd0};
            cnt_d = 3'd1;
            tok_d = ACCUM;
        end else if (acc && is_dig && state_q == ACCUM && cnt_q == 3'd4) begin
            err_d = 1'b1;
            tok_d = DISCARD;
        end else if (acc && is_dig && state_q == ACCUM) begin
            bcd_d = '{b[3:0], bcd_q[0], bcd_q[1], bcd_q[2]};
            cnt_d = cnt_q + 3'd1;
        end else if (acc && is_bs && state_q == ACCUM) begin
            bcd_d = '{bcd_q[1], bcd_q[2], bcd_q[3], 4'd0};
            cnt_d = cnt_q - 3'd1;
            tok_d = cnt_q == 3'd1 ? IDLE : ACCUM;
        end else if (acc && is_del && state_q == ACCUM) begin
            data_d = 16'(bcd_q[3]) * 16'd1000 + 16'(bcd_q[2]) * 16'd100
                   + 16'(bcd_q[1]) * 16'd10 + 16'(bcd_q[0]);
            tok_d  = EMIT;
        end else if (acc && is_del && state_q == DISCARD) begin
            bcd_d = '{default: 4'd0};
            cnt_d = 3'd0;
            tok_d = IDLE;
        end else if (acc && !is_dig && !is_del && !is_bs && state_q != DISCARD) begin
            err_d = 1'b1;
            tok_d = DISCARD;
        end
`ifdef STDIN_ECHO_EN
        state_d = acc ? ECHO : state_q;
        ret_d   = acc ? tok_d : ret_q;
        echo_d  = acc ? b : echo_q;
        if (state_q == ECHO && bus.echo_rdy_i) state_d = ret_q;
`else
        state_d = tok_d;
`endif
        if (state_q == EMIT && bus.stdin_rdy_i) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            bcd_q   <= '{default: 4'd0};
            data_q  <= 16'd0;
            err_q   <= 1'b0;
`ifdef STDIN_ECHO_EN
            ret_q   <= IDLE;
            echo_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef STDIN_ECHO_EN
            ret_q   <= ret_d;
            echo_q  <= echo_d;
`endif
        end
    end
endmodule

// File: tb/tb_stdin.sv
// tb_stdin: directed and random byte streams for stdin, checked against a token-level model.
module tb_stdin;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  lcd [0:3];
    logic        err;
    logic [15:0] lcd_packed;
    stdin_if bus();
    stdin dut (.clk_i(clk), .rst_i(rst), .bus(bus), .lcd_bcd_o(lcd), .err_o(err));
    always #5 clk = ~clk;
    assign lcd_packed = {lcd[3], lcd[2], lcd[1], lcd[0]};
    int n_pass = 0, n_chk = 0;
    int err_seen = 0, err_exp = 0, n_xfer = 0;
    int tok[$], shown[$], expq[$];
    bit disc = 0;
    bit rdy_rand = 0, rdy_fix = 1;
    logic [15:0] last_word = 16'd0, prev_data = 16'd0;
    logic        prev_val = 1'b0;
    logic [7:0]  last_byte = 8'd0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    function automatic void model_reset();
        tok.delete();
        shown.delete();
        expq.delete();
        disc = 0;
    endfunction
    // Token-level reference: tok holds typed digits (oldest first), shown is what the display shows.
    function automatic void model(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            if (!disc && tok.size() == 4) begin
                err_exp++;
                disc = 1;
            end else if (!disc) begin
                tok.push_back(int'(c) - 48);
                shown = tok;
            end
        end else if (c == 8'h08) begin
            if (!disc && tok.size() > 0) begin
                void'(tok.pop_back());
                shown = tok;
            end
        end else if (c == 8'h20 || c == 8'h0a || c == 8'h0d) begin
            if (disc) begin
                disc = 0;
                tok.delete();
                shown.delete();
            end else if (tok.size() > 0) begin
                int v = 0;
                foreach (tok[i]) v = v * 10 + tok[i];
                expq.push_back(v);
                tok.delete();
            end
        end else if (!disc) begin
            err_exp++;
            disc = 1;
        end
    endfunction
    function automatic logic [15:0] exp_lcd();
        logic [15:0] r = 16'd0;
        for (int i = 0; i < 4; i++)
            if (i < shown.size()) r[4*i +: 4] = 4'(shown[shown.size() - 1 - i]);
        return r;
    endfunction
    task automatic put(input logic [7:0] c);
        bit ok = 0;
        @(posedge clk); #2;
        bus.uart_val_i  = 1'b1;
        bus.uart_data_i = c;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.uart_rdy_o;
        end
        if (!ok) begin
            check("put_timeout", 0, 1);
            bus.uart_val_i = 1'b0;
            return;
        end
        @(posedge clk); #2;
        bus.uart_val_i = 1'b0;
        last_byte = c;
        model(c);
        @(negedge clk);
        check("lcd", lcd_packed, exp_lcd());
    endtask
    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask
    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.uart_rdy_o;
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask
    function automatic logic [7:0] rand_byte();
        int r = $urandom % 20;
        logic [7:0] dl [3] = '{8'h20, 8'h0a, 8'h0d};
        if (r < 11) return 8'(8'h30 + $urandom % 10);
        if (r < 15) return dl[$urandom % 3];
        if (r < 17) return 8'h08;
        return 8'($urandom_range(8'h21, 8'h2f));
    endfunction
    initial forever begin
        @(posedge clk); #2;
        bus.stdin_rdy_i = rdy_rand ? 1'($urandom % 2) : rdy_fix;
`ifdef STDIN_ECHO_EN
        bus.echo_rdy_i = 1'($urandom % 2);
`endif
    end
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (err) err_seen++;
            if (bus.stdin_val_o) check("val_blocks_uart", bus.uart_rdy_o, 0);
            if (bus.stdin_val_o && prev_val) check("data_hold", bus.stdin_data_o, prev_data);
            if (bus.stdin_val_o && bus.stdin_rdy_i) begin
                n_xfer++;
                last_word = bus.stdin_data_o;
                if (expq.size() == 0) check("unexpected_word", bus.stdin_data_o, 16'hffff);
                else check("word", bus.stdin_data_o, expq.pop_front());
            end
`ifdef STDIN_ECHO_EN
            if (bus.echo_val_o) check("echo_data", bus.echo_data_o, last_byte);
`endif
            prev_val  = bus.stdin_val_o && !bus.stdin_rdy_i;
            prev_data = bus.stdin_data_o;
        end else prev_val = 1'b0;
    end
    initial begin
        int e0, x0;
        bit ok;
        bus.uart_val_i  = 1'b0;
        bus.uart_data_i = 8'd0;
        bus.stdin_rdy_i = 1'b1;
`ifdef STDIN_ECHO_EN
        bus.echo_rdy_i  = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_lcd", lcd_packed, 0);
        check("rst_val", bus.stdin_val_o, 0);
        check("rst_data", bus.stdin_data_o, 0);
        check("rst_err", err, 0);
        check("rst_uart_rdy", bus.uart_rdy_o, 1);
        put_str("123\n");
        drain();
        check("w123_word", last_word, 123);
        check("w123_lcd", lcd_packed, 16'h0123);
        check("w123_xfer", n_xfer, 1);
        e0 = err_seen;
        put_str("99999 ");
        drain();
        check("five_digit_err", err_seen - e0, 1);
        check("five_digit_xfer", n_xfer, 1);
        put_str("7 ");
        drain();
        check("w7_word", last_word, 7);
        put("4"); put("5"); put(8'h08); put("6"); put(8'h0d);
        drain();
        check("bs_word", last_word, 46);
        check("bs_lcd", lcd_packed, 16'h0046);
        e0 = err_seen;
        x0 = n_xfer;
        put_str("1x2 ");
        drain();
        check("other_err", err_seen - e0, 1);
        check("other_xfer", n_xfer - x0, 0);
        e0 = err_seen;
        put(8'h0a);
        drain();
        check("idle_nl_err", err_seen - e0, 0);
        check("idle_nl_xfer", n_xfer - x0, 0);
        rdy_fix = 0;
        x0 = n_xfer;
        put_str("5 ");
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.stdin_val_o;
        end
        check("stall_val_seen", ok, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_val", bus.stdin_val_o, 1);
            check("stall_uart_rdy", bus.uart_rdy_o, 0);
            check("stall_data", bus.stdin_data_o, 5);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        rdy_fix = 1;
        @(negedge clk);
        check("stall_rst_val", bus.stdin_val_o, 0);
        check("stall_rst_lcd", lcd_packed, 0);
        check("stall_rst_uart_rdy", bus.uart_rdy_o, 1);
        repeat (3) @(negedge clk);
        check("stall_rst_xfer", n_xfer - x0, 0);
        rdy_rand = 1;
        repeat (400) put(rand_byte());
        rdy_rand = 0;
        rdy_fix = 1;
        drain();
        repeat (3) @(negedge clk);
        check("end_words_left", expq.size(), 0);
        check("end_err_count", err_seen, err_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stdin.md
STDIN -- requirements
Module: stdin

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: uart_val_i  in  1 / uart_data_i  in  8 / uart_rdy_o  out  1  received ASCII byte stream; byte accepted when uart_val_i && uart_rdy_o.
REQ-004 SHALL have ports: stdin_val_o  out  1 / stdin_data_o  out  16 / stdin_rdy_i  in  1  parsed word to the machine; word transferred when stdin_val_o && stdin_rdy_i.
REQ-005 SHALL have port: lcd_bcd_o[0:3]  out  4 each  digits of the token being typed; [0] is least significant.
REQ-006 SHALL have port: err_o  out  1  one-cycle pulse when a token is rejected.
REQ-007 SHALL have ports (STDIN_ECHO_EN only): echo_val_o  out  1 / echo_data_o  out  8 / echo_rdy_i  in  1  echo of accepted bytes toward the UART transmitter.

Function
REQ-008 SHALL classify bytes: DIGIT "0"-"9"; DELIM " ", "\n", "\r"; BS 0x08; everything else OTHER.
REQ-009 SHALL implement states IDLE (no digits held), ACCUM (1-4 digits held), DISCARD (rejecting token), EMIT (word offered), ECHO (echo pending, STDIN_ECHO_EN only).
REQ-010 SHALL drive uart_rdy_o=1 only in IDLE, ACCUM, DISCARD; 0 in EMIT and ECHO.
REQ-011 IDLE+DIGIT SHALL clear lcd_bcd_o[1..3], load digit into lcd_bcd_o[0], set count=1, go ACCUM.
REQ-012 ACCUM+DIGIT with count<4 SHALL shift lcd_bcd_o up one position ([3]<=[2]..[0]<=digit), count+1; with count==4 SHALL pulse err_o, go DISCARD.
REQ-013 ACCUM+BS SHALL shift lcd_bcd_o down ([0]<=[1]..[3]<=0), count-1; go IDLE when count reaches 0. BS in IDLE and DISCARD SHALL be ignored.
REQ-014 ACCUM+DELIM SHALL register stdin_data_o = ((d3*10+d2)*10+d1)*10+d0, zero-extended to 16 bits (max 9999), go EMIT; lcd_bcd_o unchanged.
REQ-015 DELIM in IDLE SHALL be ignored; DELIM in DISCARD SHALL clear lcd_bcd_o and count, go IDLE.
REQ-016 OTHER in IDLE or ACCUM SHALL pulse err_o, go DISCARD; OTHER in DISCARD SHALL stay without further err_o.
REQ-017 EMIT SHALL hold stdin_val_o=1 and stdin_data_o stable until stdin_rdy_i; on transfer go IDLE, count=0, uart_rdy_o=1 next cycle; lcd_bcd_o keeps the value until next token's first digit.
REQ-018 Byte-accept-to-stdin_val_o latency SHALL be 1 cycle without echo, echo handshake + 1 cycle with echo.
REQ-019 err_o SHALL assert in the cycle after the offending byte is accepted, for exactly one cycle.

Reset
REQ-020 rst_i SHALL force IDLE, count=0, lcd_bcd_o all 0, stdin_data_o=0, stdin_val_o=0, err_o=0, echo_val_o=0, echo_data_o=0; uart_rdy_o=1 the first cycle after reset release.
REQ-021 rst_i asserted during EMIT or ECHO SHALL discard the pending word/echo with no transfer.
REQ-022 rst_i SHALL take priority over every input in the same cycle.

Configuration
REQ-023 Macro STDIN_ECHO_EN defined: every accepted byte SHALL be registered into echo_data_o, state goes ECHO with echo_val_o=1 until echo_rdy_i, then to the state REQ-011..016 computed; classification updates (lcd, count, err_o) occur at acceptance, not after echo.
REQ-024 STDIN_ECHO_EN undefined: echo ports and ECHO state SHALL not exist; behaviour otherwise identical.

Verification
REQ-025 Bytes "1","2","3","\n", stdin_rdy_i=1 -> stdin_data_o=0x007B (123), lcd_bcd_o={3,2,1,0} ([0..3]), one transfer.
REQ-026 "9","9","9","9","9"," " -> err_o one pulse after 5th digit, no stdin_val_o; next "7"," " -> 0x0007.
REQ-027 "4","5",0x08,"6","\r" -> 0x002E (46); lcd_bcd_o[0]=6,[1]=4.
REQ-028 "1","x","2"," " -> single err_o pulse, no word; "\n" alone in IDLE -> no word, no error.
REQ-029 "5"," " with stdin_rdy_i=0 for 10 cycles -> stdin_val_o held, uart_rdy_o=0 throughout, data 0x0005 stable; rst_i pulse mid-wait -> word dropped, lcd 0.
REQ-030 STDIN_ECHO_EN, echo_rdy_i=0 for 3 cycles on "8" -> echo_data_o=0x38 held, uart_rdy_o=0 until echo_rdy_i, then "\n" -> 0x0008.
